pitch_detector: RTL and testbench
=================================

Name: pitch_detector

Overview:
- Receive-side counterpart of the pitch lookup plus oscillator chain: takes a square-wave tone (e.g. oscillator out or an external pin) and recovers the scale degree and gate that produced it.
- Measures the full period between rising edges, then searches the shared pitch-period table sequentially.
- Debounces matches and reports a stable degree/gate pair, plus a one-cycle change strobe for LEDs or a sequencer recorder.

Parameters:
PERIOD_W, 19, width of the period counter; a full period is 2*(counter_top+1) with an 18-bit counter_top.
TOL_SHIFT, 5, match tolerance: |measured - table[d]| <= table[d] >> TOL_SHIFT.
LOCK_COUNT, 3, consecutive matching periods needed before the reported degree changes.
MAX_PERIOD, 19'h7FFFF, timeout count with no rising edge; reaching it means silence.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
tone_in  input  1  asynchronous square wave to analyse
scale_degree  output  4  recovered degree 1..15; 0 = silence/unknown
gate  output  1  high while a degree is locked
valid  output  1  one-cycle strobe whenever scale_degree/gate change
period  output  PERIOD_W  last completed period measurement, in clk cycles

Behaviour:
- Reset (rst low, async assert, sync deassert via registers): scale_degree=0, gate=0, valid=0, period=0, FSM=IDLE, all counters and synchroniser flops cleared.
- Input path: 2-flop synchroniser on tone_in, then a third flop for rising-edge detect. An edge is recognised 3 clk after the pin rises.
- Period counter increments every clk and saturates at MAX_PERIOD. On an edge: the counter value +1 goes to period, the counter restarts at 0.
- FSM states:
  - IDLE: wait for the first edge, which only starts the counter (no measurement) -> ARMED.
  - ARMED: on the next edge, capture period -> SEARCH.
  - SEARCH: idx walks 1..15, one table entry per clk; on the first entry within tolerance, cand=idx -> QUALIFY; if none matches, cand=0 -> QUALIFY. Worst-case latency is 15 clk.
  - QUALIFY (1 clk): if cand==last_cand and cand!=0, match_cnt++ (saturating); otherwise last_cand=cand and match_cnt=1, or 0 if cand==0. If match_cnt reaches LOCK_COUNT and cand!=scale_degree: scale_degree=cand, gate=1, valid=1 for one clk. -> ARMED.
  - Any state: counter reaching MAX_PERIOD -> IDLE, match_cnt=0; if gate was 1 then gate=0, scale_degree=0, valid=1.
- An edge arriving during SEARCH/QUALIFY still restarts the counter. That period is measured normally; search is never aborted. Periods shorter than 17 clk are out of spec.
- Tolerance arithmetic uses PERIOD_W+1 bits (no wrap). Ties resolve to the lowest index.
- Once locked, a degree holds until either a different degree qualifies for LOCK_COUNT periods or a timeout occurs. Unmatched periods (cand=0) do not clear the lock; only timeout does.
- valid never asserts twice in consecutive cycles and never without a change in scale_degree/gate.

Decomposition:
- Shared package pitch_pkg holds:
  - the 16-entry table of full periods, PERIOD_TABLE[d] = 2*(counter_top(d)+1), with entry 0 unused;
  - PERIOD_W;
  - the degree width (4).
- The existing pitch lookup is refactored to read counter_top from the same package, so encoder and decoder stay consistent.
- One sub-module, tone_edge_sync: 2-flop synchroniser plus rising-edge pulse, with the same clk/rst.

Test Plan:
- Reset mid-lock: lock degree 5, pull rst low asynchronously between clk edges -> all outputs 0 immediately; after release, relock requires LOCK_COUNT fresh periods.
- Drive the oscillator with counter_top for degree 3 (period = PERIOD_TABLE[3]) -> valid pulses once after the 4th rising edge (1 arm + 3 lock); scale_degree=3, gate=1, period=PERIOD_TABLE[3].
- Switch to degree 7 while locked on 3 -> scale_degree stays 3 for two periods, becomes 7 on the third qualifying period with one valid pulse.
- Tolerance edge: period = PERIOD_TABLE[4] + (PERIOD_TABLE[4]>>5) locks to 4; period one cycle larger gives no match and no lock.
- Hold tone_in low after lock -> exactly MAX_PERIOD clk after the last edge, gate=0, scale_degree=0, single valid pulse; no further pulses while silent.
- Alternate periods for degree 2 and degree 9 every edge -> never locks; gate stays 0, valid never pulses.

Source files
------------

// File: rtl/pitch_pkg.sv
// Shared pitch-period table: the oscillator's pitch lookup and the detector both read it,
// so the note encoder and decoder cannot drift apart.
package pitch_pkg;

  localparam int PERIOD_W = 19;
  localparam int DEG_W    = 4;
  localparam int NUM_DEG  = 16;

  typedef logic [DEG_W-1:0] degree_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SEARCH,
    ST_QUALIFY
  } det_state_t;

  // Full periods in clk cycles, PERIOD_TABLE[d] = 2*(counter_top(d)+1); entry 0 unused
  localparam logic [PERIOD_W-1:0] PERIOD_TABLE [NUM_DEG] = '{
    19'd0,   19'd960, 19'd854, 19'd768, 19'd720, 19'd640, 19'd576, 19'd512,
    19'd480, 19'd426, 19'd384, 19'd360, 19'd320, 19'd288, 19'd256, 19'd240
  };

  function automatic logic [17:0] counter_top(input degree_t d);
    logic [PERIOD_W-1:0] half;
    half = PERIOD_TABLE[d] >> 1;
    return (d == '0) ? '0 : 18'(half - PERIOD_W'(1));
  endfunction

endpackage

// File: rtl/tone_edge_sync.sv
// Two-flop synchroniser for the external tone pin plus a rising-edge pulse.
module tone_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic tone_in,
  output logic rise
);

  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sh <= '0;
    else      sh <= {sh[1:0], tone_in};
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/pitch_detector.sv
// Recovers scale degree and gate from a square-wave tone by timing full periods and
// searching the shared period table, with lock debouncing and a change strobe.
module pitch_detector #(
  parameter int                  PERIOD_W   = pitch_pkg::PERIOD_W,
  parameter int                  TOL_SHIFT  = 5,
  parameter int                  LOCK_COUNT = 3,
  parameter logic [PERIOD_W-1:0] MAX_PERIOD = '1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tone_in,
  output logic [pitch_pkg::DEG_W-1:0]  scale_degree,
  output logic                         gate,
  output logic                         valid,
  output logic [PERIOD_W-1:0]          period
);

  import pitch_pkg::*;

  localparam int                  CNT_W      = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]    LOCK_V     = CNT_W'(LOCK_COUNT);
  localparam logic [PERIOD_W-1:0] TIMEOUT_AT = MAX_PERIOD - PERIOD_W'(1);

  logic                rise;
  logic [PERIOD_W-1:0] cnt;
  logic                timeout;
  det_state_t          state, state_nx;
  degree_t             idx, cand, last_cand, last_nx;
  logic [CNT_W-1:0]    match_cnt, mc_nx;
  logic                lock_now;
  logic [PERIOD_W:0]   ref_p, meas_p, diff, tol;
  logic                hit;

  tone_edge_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .tone_in (tone_in),
    .rise    (rise)
  );

  // Fires on the cycle the counter steps onto MAX_PERIOD, so silence is flagged once
  assign timeout = !rise && (cnt == TIMEOUT_AT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (rise)              cnt <= '0;
    else if (cnt != MAX_PERIOD) cnt <= cnt + PERIOD_W'(1);
  end

  always_comb begin
    ref_p  = (PERIOD_W+1)'(PERIOD_TABLE[idx]);
    meas_p = {1'b0, period};
    diff   = (meas_p >= ref_p) ? (meas_p - ref_p) : (ref_p - meas_p);
    tol    = ref_p >> TOL_SHIFT;
    hit    = (diff <= tol);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (rise) state_nx = ST_ARMED;
      ST_ARMED:   if (rise) state_nx = ST_SEARCH;
      ST_SEARCH:  if (hit || idx == 4'd15) state_nx = ST_QUALIFY;
      ST_QUALIFY: state_nx = ST_ARMED;
      default:    state_nx = ST_IDLE;
    endcase
    if (timeout) state_nx = ST_IDLE;
  end

  always_comb begin
    mc_nx   = match_cnt;
    last_nx = last_cand;
    if (cand == last_cand && cand != '0) begin
      mc_nx = (match_cnt == LOCK_V) ? match_cnt : match_cnt + CNT_W'(1);
    end else begin
      last_nx = cand;
      mc_nx   = (cand != '0) ? CNT_W'(1) : '0;
    end
    lock_now = (mc_nx == LOCK_V) && (cand != scale_degree);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period       <= '0;
      idx          <= '0;
      cand         <= '0;
      last_cand    <= '0;
      match_cnt    <= '0;
      scale_degree <= '0;
      gate         <= 1'b0;
      valid        <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (timeout) begin
        match_cnt <= '0;
        last_cand <= '0;
        if (gate) begin
          gate         <= 1'b0;
          scale_degree <= '0;
          valid        <= 1'b1;
        end
      end else begin
        case (state)
          ST_ARMED: begin
            if (rise) begin
              period <= cnt + PERIOD_W'(1);
              idx    <= 4'd1;
            end
          end
          ST_SEARCH: begin
            if (hit)              cand <= idx;
            else if (idx == 4'd15) cand <= '0;
            else                  idx  <= idx + 4'd1;
          end
          ST_QUALIFY: begin
            match_cnt <= mc_nx;
            last_cand <= last_nx;
            if (lock_now) begin
              scale_degree <= cand;
              gate         <= 1'b1;
              valid        <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pitch_detector.sv
// Directed bench for pitch_detector: square-wave periods driven from the bench,
// outputs compared against hand-computed degrees, periods and strobe counts.
module tb_pitch_detector;

  localparam int MAXP = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tone_in = 1'b0;
  logic [3:0]  scale_degree;
  logic        gate;
  logic        valid;
  logic [18:0] period;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt = 0;
  int dbl = 0;
  logic prev_v = 1'b0;

  pitch_detector #(
    .PERIOD_W   (19),
    .TOL_SHIFT  (5),
    .LOCK_COUNT (3),
    .MAX_PERIOD (19'd3000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tone_in      (tone_in),
    .scale_degree (scale_degree),
    .gate         (gate),
    .valid        (valid),
    .period       (period)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled 2 time units after each rising edge
  always @(posedge clk) begin
    #2;
    if (valid) begin
      vcnt++;
      if (prev_v) dbl++;
    end
    prev_v = valid;
  end

  task automatic drive_period(input int p);
    tone_in = 1'b1;
    repeat (p / 2) @(negedge clk);
    tone_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  task automatic drive_n(input int p, input int n);
    for (int i = 0; i < n; i++) drive_period(p);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if (scale_degree !== 4'd0) begin n_bad++; $display("FAIL reset_degree: got %0d want 0", scale_degree); end
    n_cmp++; if (gate !== 1'b0) begin n_bad++; $display("FAIL reset_gate: got %b want 0", gate); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (period !== 19'd0) begin n_bad++; $display("FAIL reset_period: got %0d want 0", period); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lock_deg3;
    int v0;
    v0 = vcnt;
    drive_n(768, 3);
    n_cmp++; if (gate !== 1'b0) begin n_bad++; $display("FAIL deg3_early_gate: got %b want 0", gate); end
    n_cmp++; if (vcnt - v0 !== 0) begin n_bad++; $display("FAIL deg3_early_valid: got %0d pulses want 0", vcnt - v0); end
    drive_period(768);
    n_cmp++; if (scale_degree !== 4'd3) begin n_bad++; $display("FAIL deg3_degree: got %0d want 3", scale_degree); end
    n_cmp++; if (gate !== 1'b1) begin n_bad++; $display("FAIL deg3_gate: got %b want 1", gate); end
    n_cmp++; if (period !== 19'd768) begin n_bad++; $display("FAIL deg3_period: got %0d want 768", period); end
    n_cmp++; if (vcnt - v0 !== 1) begin n_bad++; $display("FAIL deg3_valid: got %0d pulses want 1", vcnt - v0); end
  endtask

  task automatic test_switch_deg7;
    int v0;
    v0 = vcnt;
    drive_n(512, 3);
    n_cmp++; if (scale_degree !== 4'd3) begin n_bad++; $display("FAIL sw7_hold_degree: got %0d want 3", scale_degree); end
    n_cmp++; if (vcnt - v0 !== 0) begin n_bad++; $display("FAIL sw7_hold_valid: got %0d pulses want 0", vcnt - v0); end
    drive_period(512);
    n_cmp++; if (scale_degree !== 4'd7) begin n_bad++; $display("FAIL sw7_degree: got %0d want 7", scale_degree); end
    n_cmp++; if (gate !== 1'b1) begin n_bad++; $display("FAIL sw7_gate: got %b want 1", gate); end
    n_cmp++; if (period !== 19'd512) begin n_bad++; $display("FAIL sw7_period: got %0d want 512", period); end
    n_cmp++; if (vcnt - v0 !== 1) begin n_bad++; $display("FAIL sw7_valid: got %0d pulses want 1", vcnt - v0); end
  endtask

  // Last rise was 512 negedges ago; recognised edge lands 2.5 clk after the rise,
  // so gate falls between negedge rise+MAXP+2 and rise+MAXP+3.
  task automatic test_timeout;
    int v0;
    v0 = vcnt;
    repeat (MAXP + 2 - 512) @(negedge clk);
    n_cmp++; if (gate !== 1'b1) begin n_bad++; $display("FAIL to_before_gate: got %b want 1", gate); end
    n_cmp++; if (scale_degree !== 4'd7) begin n_bad++; $display("FAIL to_before_degree: got %0d want 7", scale_degree); end
    @(negedge clk);
    n_cmp++; if (gate !== 1'b0) begin n_bad++; $display("FAIL to_gate: got %b want 0", gate); end
    n_cmp++; if (scale_degree !== 4'd0) begin n_bad++; $display("FAIL to_degree: got %0d want 0", scale_degree); end
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL to_valid: got %b want 1", valid); end
    @(negedge clk);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL to_valid_end: got %b want 0", valid); end
    repeat (2 * MAXP) @(negedge clk);
    n_cmp++; if (vcnt - v0 !== 1) begin n_bad++; $display("FAIL to_silent_valid: got %0d pulses want 1", vcnt - v0); end
  endtask

  task automatic test_tolerance;
    int v0;
    v0 = vcnt;
    drive_n(743, 4);
    n_cmp++; if (gate !== 1'b0) begin n_bad++; $display("FAIL tol743_gate: got %b want 0", gate); end
    n_cmp++; if (scale_degree !== 4'd0) begin n_bad++; $display("FAIL tol743_degree: got %0d want 0", scale_degree); end
    n_cmp++; if (period !== 19'd743) begin n_bad++; $display("FAIL tol743_period: got %0d want 743", period); end
    n_cmp++; if (vcnt - v0 !== 0) begin n_bad++; $display("FAIL tol743_valid: got %0d pulses want 0", vcnt - v0); end
    drive_n(742, 4);
    n_cmp++; if (scale_degree !== 4'd4) begin n_bad++; $display("FAIL tol742_degree: got %0d want 4", scale_degree); end
    n_cmp++; if (gate !== 1'b1) begin n_bad++; $display("FAIL tol742_gate: got %b want 1", gate); end
    n_cmp++; if (period !== 19'd742) begin n_bad++; $display("FAIL tol742_period: got %0d want 742", period); end
    n_cmp++; if (vcnt - v0 !== 1) begin n_bad++; $display("FAIL tol742_valid: got %0d pulses want 1", vcnt - v0); end
    repeat (MAXP + 10) @(negedge clk);
    n_cmp++; if (gate !== 1'b0) begin n_bad++; $display("FAIL tol_silence_gate: got %b want 0", gate); end
  endtask

  task automatic test_alternate;
    int v0;
    v0 = vcnt;
    for (int i = 0; i < 4; i++) begin
      drive_period(854);
      drive_period(426);
    end
    n_cmp++; if (gate !== 1'b0) begin n_bad++; $display("FAIL alt_gate: got %b want 0", gate); end
    n_cmp++; if (scale_degree !== 4'd0) begin n_bad++; $display("FAIL alt_degree: got %0d want 0", scale_degree); end
    n_cmp++; if (period !== 19'd854) begin n_bad++; $display("FAIL alt_period: got %0d want 854", period); end
    n_cmp++; if (vcnt - v0 !== 0) begin n_bad++; $display("FAIL alt_valid: got %0d pulses want 0", vcnt - v0); end
    repeat (MAXP + 10) @(negedge clk);
  endtask

  task automatic test_reset_mid_lock;
    int v0;
    drive_n(640, 4);
    n_cmp++; if (scale_degree !== 4'd5) begin n_bad++; $display("FAIL rml_pre_degree: got %0d want 5", scale_degree); end
    n_cmp++; if (gate !== 1'b1) begin n_bad++; $display("FAIL rml_pre_gate: got %b want 1", gate); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (scale_degree !== 4'd0) begin n_bad++; $display("FAIL rml_degree: got %0d want 0", scale_degree); end
    n_cmp++; if (gate !== 1'b0) begin n_bad++; $display("FAIL rml_gate: got %b want 0", gate); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rml_valid: got %b want 0", valid); end
    n_cmp++; if (period !== 19'd0) begin n_bad++; $display("FAIL rml_period: got %0d want 0", period); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    v0 = vcnt;
    drive_n(640, 3);
    n_cmp++; if (gate !== 1'b0) begin n_bad++; $display("FAIL rml_relock_early_gate: got %b want 0", gate); end
    n_cmp++; if (vcnt - v0 !== 0) begin n_bad++; $display("FAIL rml_relock_early_valid: got %0d pulses want 0", vcnt - v0); end
    drive_period(640);
    n_cmp++; if (scale_degree !== 4'd5) begin n_bad++; $display("FAIL rml_relock_degree: got %0d want 5", scale_degree); end
    n_cmp++; if (gate !== 1'b1) begin n_bad++; $display("FAIL rml_relock_gate: got %b want 1", gate); end
    n_cmp++; if (vcnt - v0 !== 1) begin n_bad++; $display("FAIL rml_relock_valid: got %0d pulses want 1", vcnt - v0); end
  endtask

  task automatic test_valid_spacing;
    n_cmp++; if (dbl !== 0) begin n_bad++; $display("FAIL valid_back_to_back: got %0d adjacent pulses want 0", dbl); end
  endtask

  initial begin
    test_reset;
    test_lock_deg3;
    test_switch_deg7;
    test_timeout;
    test_tolerance;
    test_alternate;
    test_reset_mid_lock;
    test_valid_spacing;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
